// File: rtl/uart_alu_pkg.sv
// +---------------------------------------------------------------------------+
// | uart_alu_pkg : shared state encoding and defaults for the UART/ALU framer |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

package uart_alu_pkg;

   localparam int unsigned STATE_W       = 3;
   localparam int unsigned DEF_BUS_SIZE  = 8;
   localparam int unsigned DEF_RES_BYTES = 2;
   localparam int unsigned RES_W         = DEF_RES_BYTES * DEF_BUS_SIZE;
   localparam logic [7:0]  DEF_SYNC_BYTE = 8'hA5;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE   = 3'd0,
      ST_GET_A  = 3'd1,
      ST_GET_B  = 3'd2,
      ST_GET_OP = 3'd3,
      ST_EXEC   = 3'd4,
      ST_SEND   = 3'd5
   } state_e;

   // Width of an index over n items; never narrower than one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/uart_frame_timer.sv
// +---------------------------------------------------------------------------+
// | uart_frame_timer : inter-byte idle counter, expires after TIMEOUT_CYC     |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module uart_frame_timer #(
   parameter int unsigned TIMEOUT_CYC = 50000
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expire
);

   if (TIMEOUT_CYC == 0) begin : g_no_timer
      logic w_unused;
      assign w_unused = &{1'b0, clk, reset, i_clr, i_en};
      assign o_expire = 1'b0;
   end else begin : g_timer
      localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
      localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYC - 1);

      logic [TW-1:0] cnt_q;
      logic [TW-1:0] cnt_d;

      // The TIMEOUT_CYC-th consecutive idle cycle is the one that expires.
      assign o_expire = i_en && !i_clr && (cnt_q == LAST);

      always_comb begin
         cnt_d = cnt_q;
         if (i_clr) begin
            cnt_d = '0;
         end else if (i_en) begin
            cnt_d = o_expire ? '0 : cnt_q + TW'(1);
         end
      end

      always_ff @(posedge clk) begin
         if (!reset) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_d;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/uart_alu_frame_ctrl.sv
// +---------------------------------------------------------------------------+
// | uart_alu_frame_ctrl : RX frame collector -> ALU -> multi-byte TX streamer |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module uart_alu_frame_ctrl
   import uart_alu_pkg::*;
#(
   parameter int unsigned          BUS_SIZE    = DEF_BUS_SIZE,
   parameter int unsigned          OP_SIZE     = 6,
   parameter int unsigned          RES_BYTES   = DEF_RES_BYTES,
   parameter int unsigned          USE_SYNC    = 1,
   parameter logic [BUS_SIZE-1:0]  SYNC_BYTE   = BUS_SIZE'(DEF_SYNC_BYTE),
   parameter int unsigned          TIMEOUT_CYC = 50000
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [BUS_SIZE-1:0]           i_rx_data,
   input  logic                          i_rx_empty,
   output logic                          o_rd,
   input  logic                          i_tx_full,
   output logic                          o_wr,
   output logic [BUS_SIZE-1:0]           o_tx_data,
   output logic [BUS_SIZE-1:0]           o_op_a,
   output logic [BUS_SIZE-1:0]           o_op_b,
   output logic [OP_SIZE-1:0]            o_op_code,
   input  logic [RES_BYTES*BUS_SIZE-1:0] i_alu_result,
   output logic                          o_busy,
   output logic                          o_frame_done,
   output logic                          o_timeout
);

   localparam int unsigned CNT_W = idx_width(RES_BYTES);

   state_e                             state_q, state_d;
   logic [BUS_SIZE-1:0]                op_a_q, op_a_d;
   logic [BUS_SIZE-1:0]                op_b_q, op_b_d;
   logic [OP_SIZE-1:0]                 op_code_q, op_code_d;
   logic [RES_BYTES-1:0][BUS_SIZE-1:0] result_q, result_d;
   logic [CNT_W-1:0]                   byte_cnt_q, byte_cnt_d;
   logic                               timeout_q, timeout_d;

   logic w_get;
   logic w_rd;
   logic w_wr;
   logic w_last;
   logic w_expire;

   assign w_get  = (state_q == ST_GET_A) || (state_q == ST_GET_B) || (state_q == ST_GET_OP);
   // Without sync hunting, IDLE only watches the FIFO; GET_A performs the first pop.
   assign w_rd   = reset && !i_rx_empty &&
                   (w_get || ((state_q == ST_IDLE) && (USE_SYNC != 0)));
   assign w_wr   = reset && (state_q == ST_SEND) && !i_tx_full;
   assign w_last = (byte_cnt_q == CNT_W'(RES_BYTES - 1));

   uart_frame_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .i_clr    (!w_get || w_rd),
      .i_en     (w_get && i_rx_empty),
      .o_expire (w_expire)
   );

   always_comb begin
      state_d    = state_q;
      op_a_d     = op_a_q;
      op_b_d     = op_b_q;
      op_code_d  = op_code_q;
      result_d   = result_q;
      byte_cnt_d = byte_cnt_q;
      timeout_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (USE_SYNC != 0) begin
               if (w_rd && (i_rx_data == SYNC_BYTE)) begin
                  state_d = ST_GET_A;
               end
            end else if (!i_rx_empty) begin
               state_d = ST_GET_A;
            end
         end
         ST_GET_A: begin
            if (w_rd) begin
               op_a_d  = i_rx_data;
               state_d = ST_GET_B;
            end else if (w_expire) begin
               state_d   = ST_IDLE;
               timeout_d = 1'b1;
            end
         end
         ST_GET_B: begin
            if (w_rd) begin
               op_b_d  = i_rx_data;
               state_d = ST_GET_OP;
            end else if (w_expire) begin
               state_d   = ST_IDLE;
               timeout_d = 1'b1;
            end
         end
         ST_GET_OP: begin
            if (w_rd) begin
               op_code_d = i_rx_data[OP_SIZE-1:0];
               state_d   = ST_EXEC;
            end else if (w_expire) begin
               state_d   = ST_IDLE;
               timeout_d = 1'b1;
            end
         end
         ST_EXEC: begin
            result_d   = i_alu_result;
            byte_cnt_d = '0;
            state_d    = ST_SEND;
         end
         ST_SEND: begin
            if (w_wr) begin
               byte_cnt_d = byte_cnt_q + CNT_W'(1);
               if (w_last) begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         op_a_q     <= '0;
         op_b_q     <= '0;
         op_code_q  <= '0;
         result_q   <= '0;
         byte_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_a_q     <= op_a_d;
         op_b_q     <= op_b_d;
         op_code_q  <= op_code_d;
         result_q   <= result_d;
         byte_cnt_q <= byte_cnt_d;
         timeout_q  <= timeout_d;
      end
   end

   assign o_rd         = w_rd;
   assign o_wr         = w_wr;
   assign o_tx_data    = result_q[byte_cnt_q];
   assign o_op_a       = op_a_q;
   assign o_op_b       = op_b_q;
   assign o_op_code    = op_code_q;
   assign o_busy       = (state_q != ST_IDLE);
   assign o_frame_done = w_wr && w_last;
   assign o_timeout    = timeout_q;

endmodule

`default_nettype wire
